// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus stores feed a byte FIFO that an
// 8N1 serializer drains onto tx at a programmable clocks-per-bit divisor.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h8000_0000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write_enable,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] write_data,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_idle
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic [15:0]   divisor;

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [15:0]   period, bit_timer, period_next;

  logic       hit, full, empty, pop, push_req, push_ok, w1c, div_wr;
  logic [1:0] off;
  logic [8:0] count_ext;
  logic       unused_bits;

  assign hit      = address[31:4] == BASE_ADDRESS[31:4];
  assign off      = address[3:2];
  assign full     = count == (AW+1)'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign pop      = (state == IDLE) && !empty;
  assign push_req = write_enable && hit && off == 2'd0 && byte_enable[0];
  // A full FIFO still accepts a byte when the serializer frees a slot the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign w1c      = write_enable && hit && off == 2'd1 && byte_enable[0] && write_data[3];
  assign div_wr   = write_enable && hit && off == 2'd2;
  assign period_next = (divisor == 16'd0) ? 16'd1 : divisor;
  assign count_ext   = 9'(count);
  assign tx_idle     = empty && (state == IDLE);
  assign unused_bits = ^{address[1:0], write_data[31:16]};

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      divisor  <= DEFAULT_DIVISOR;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (w1c)                 overflow <= 1'b0;
      if (div_wr && byte_enable[0]) divisor[7:0]  <= write_data[7:0];
      if (div_wr && byte_enable[1]) divisor[15:8] <= write_data[15:8];
    end
  end

  // tx is registered from the state, so it trails the FSM by one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      period    <= 16'd1;
      bit_timer <= '0;
      tx        <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shreg[0];
        default: tx <= 1'b1;
      endcase
      case (state)
        IDLE: if (!empty) begin
          shreg     <= mem[rd_ptr];
          period    <= period_next;
          bit_timer <= period_next - 16'd1;
          state     <= START;
        end
        START: if (bit_timer == '0) begin
          bit_timer <= period - 16'd1;
          bit_cnt   <= '0;
          state     <= DATA;
        end else bit_timer <= bit_timer - 16'd1;
        DATA: if (bit_timer == '0) begin
          bit_timer <= period - 16'd1;
          shreg     <= shreg >> 1;
          if (bit_cnt == 3'd7) state <= STOP;
          else                 bit_cnt <= bit_cnt + 3'd1;
        end else bit_timer <= bit_timer - 16'd1;
        STOP: if (bit_timer == '0) state <= IDLE;
              else                 bit_timer <= bit_timer - 16'd1;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    read_data = '0;
    if (read_enable && hit) begin
      case (off)
        2'd1:    read_data = {16'h0, count_ext[7:0], 4'h0, overflow, empty, full, state != IDLE};
        2'd2:    read_data = {16'h0, divisor};
        default: read_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench: stimulus queues expected (byte, period) frames, a tx-line
// monitor rebuilds each 8N1 waveform from those and compares cycle by cycle.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    logic [7:0] data;
    int         period;
  } frame_t;

  logic        clock = 1'b0, reset = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic        write_enable = 1'b0, read_enable = 1'b0;
  logic [3:0]  byte_enable = '0;
  logic [31:0] read_data;
  logic        tx, tx_idle;

  int total = 0, bad = 0;
  int cyc = 0;
  int start_cyc = -1;
  int cur_div = 868;
  frame_t exp_q[$];

  mmio_uart_tx dut (
    .clock(clock), .reset(reset), .address(address), .write_enable(write_enable),
    .byte_enable(byte_enable), .write_data(write_data), .read_enable(read_enable),
    .read_data(read_data), .tx(tx), .tx_idle(tx_idle)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    repeat (80000) @(posedge clock);
    $display("FAIL watchdog: run exceeded cycle budget, got %0d cycles required < 80000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clock);
    address = a; byte_enable = be; write_data = d; write_enable = 1'b1;
    @(posedge clock); #1;
    write_enable = 1'b0; byte_enable = '0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clock);
    address = a; read_enable = 1'b1;
    #1 chk(name, read_data, exp);
    read_enable = 1'b0;
  endtask

  task automatic set_div(input int d);
    wr(BASE + 32'h8, 4'b0011, 32'(d));
    cur_div = d;
  endtask

  // per = clocks per bit the frame must use; 0 means the byte is expected to be dropped
  task automatic push_byte(input logic [7:0] b, input int per);
    wr(BASE, 4'b0001, {24'h0, b});
    if (per > 0) exp_q.push_back('{b, per});
  endtask

  function automatic int eff_period();
    return (cur_div == 0) ? 1 : cur_div;
  endfunction

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    @(negedge clock);
    while (!tx_idle && n < bound) begin
      @(negedge clock);
      n++;
    end
    if (n >= bound) begin
      total++; bad++;
      $display("FAIL %s: tx_idle still 0 after %0d cycles, required 1", name, n);
    end
    repeat (3) @(negedge clock);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: any low tx while out of reset begins a frame; compare to the head of the scoreboard.
  initial begin
    frame_t     e;
    int         errs, idx, n;
    logic [7:0] got;
    logic       exp_lvl, aborted;
    forever begin
      @(negedge clock);
      if (reset && tx === 1'b0) begin
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame: tx low at cycle %0d, required idle high", cyc);
          n = 0;
          while (reset && tx === 1'b0 && n < 5000) begin
            @(negedge clock);
            n++;
          end
        end else begin
          e = exp_q.pop_front();
          errs = 0; got = '0; aborted = 1'b0;
          for (int k = 0; k < 10 * e.period; k++) begin
            if (k > 0) @(negedge clock);
            if (!reset) begin
              aborted = 1'b1;
              break;
            end
            idx = k / e.period;
            exp_lvl = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : e.data[idx-1];
            if (tx !== exp_lvl) errs++;
            if (idx >= 1 && idx <= 8 && (k % e.period) == e.period / 2) got[idx-1] = tx;
          end
          if (!aborted) begin
            total++;
            if (errs != 0 || got !== e.data) begin
              bad++;
              $display("FAIL frame: got byte %h with %0d wrong cycles, expected byte %h period %0d",
                       got, errs, e.data, e.period);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       found;
    int         n;

    // reset state
    repeat (3) @(negedge clock);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_tx_idle", 32'(tx_idle), 32'd1);
    chk("reset_read_data", read_data, 32'd0);
    reset = 1'b1;
    rd_chk("reset_status", BASE + 32'h4, 32'h0000_0004);
    rd_chk("reset_divisor", BASE + 32'h8, 32'd868);

    // single byte, period 4, with first-bit latency
    set_div(4);
    push_byte(8'hA5, 4);
    @(negedge clock); chk("lat_n0", 32'(tx), 32'd1);
    @(negedge clock); chk("lat_n1", 32'(tx), 32'd1);
    @(negedge clock); chk("lat_n2", 32'(tx), 32'd0);
    wait_idle("a5", 200);
    chk("a5_tx_idle", 32'(tx_idle), 32'd1);

    // randomized bursts at random divisors, including 0 (treated as 1)
    for (int ph = 0; ph < 6; ph++) begin
      set_div($urandom_range(0, 5));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        push_byte(b, eff_period());
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      wait_idle("rand", 1000);
    end

    // divisor change mid-frame only affects the following frame
    set_div(8);
    start_cyc = -1;
    push_byte(8'h3C, 8);
    push_byte(8'hC3, 2);
    n = 0;
    while (start_cyc < 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("div_mid_started", 32'(start_cyc >= 0), 32'd1);
    repeat (20) @(negedge clock);
    set_div(2);
    wait_idle("div_mid", 500);

    // register map: read gating, read-during-write, byte lanes, misses
    @(negedge clock);
    address = BASE + 32'h8; read_enable = 1'b0;
    #1 chk("rd_gated", read_data, 32'd0);
    @(negedge clock);
    address = BASE + 32'h8; read_enable = 1'b1; write_enable = 1'b1;
    byte_enable = 4'b0011; write_data = 32'h0000_1234;
    #1 chk("rd_during_wr", read_data, 32'h0000_0002);
    @(posedge clock); #1;
    write_enable = 1'b0; read_enable = 1'b0; byte_enable = '0;
    rd_chk("div_after_wr", BASE + 32'h8, 32'h0000_1234);
    wr(BASE + 32'h8, 4'b0010, 32'h0000_AB55);
    rd_chk("div_lane1", BASE + 32'h8, 32'h0000_AB34);
    wr(BASE + 32'h10, 4'hF, 32'h41);
    wr(32'h0000_0000, 4'hF, 32'h42);
    wr(BASE + 32'h18, 4'hF, 32'h5);
    wr(BASE + 32'hC, 4'hF, 32'hFFFF_FFFF);
    rd_chk("miss_status", BASE + 32'h4, 32'h0000_0004);
    rd_chk("miss_div", BASE + 32'h8, 32'h0000_AB34);
    rd_chk("miss_rd_hi", BASE + 32'h10, 32'd0);
    rd_chk("miss_rd_zero", 32'h0000_0000, 32'd0);
    rd_chk("rsvd_rd", BASE + 32'hC, 32'd0);
    rd_chk("txdata_rd", BASE, 32'd0);
    repeat (30) @(negedge clock);
    chk("miss_tx_idle", 32'(tx_idle), 32'd1);

    // full FIFO while the serializer sits in IDLE: push and pop together
    set_div(2);
    for (int i = 0; i < 9; i++) push_byte(8'($urandom), 2);
    rd_chk("fill_status", BASE + 32'h4, 32'h0000_0803);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      address = BASE + 32'h4; read_enable = 1'b1;
      #1;
      if (read_data[0] == 1'b0 && read_data[1] == 1'b1) begin
        b = 8'($urandom);
        read_enable = 1'b0;
        address = BASE; write_data = {24'h0, b}; byte_enable = 4'b0001; write_enable = 1'b1;
        @(posedge clock); #1;
        write_enable = 1'b0; byte_enable = '0;
        exp_q.push_back('{b, 2});
        found = 1'b1;
      end
      read_enable = 1'b0;
    end
    chk("full_idle_found", 32'(found), 32'd1);
    rd_chk("full_idle_status", BASE + 32'h4, 32'h0000_0803);
    wait_idle("full_idle", 1000);

    // overflow, W1C, then reset in the middle of data bit 3
    set_div(100);
    start_cyc = -1;
    push_byte(8'($urandom) & 8'hF7, 100);
    for (int i = 0; i < 8; i++) push_byte(8'($urandom), 100);
    push_byte(8'hEE, 0);
    rd_chk("ovf_status", BASE + 32'h4, 32'h0000_080B);
    wr(BASE + 32'h4, 4'b0001, 32'h0000_0007);
    rd_chk("w1c_nobit", BASE + 32'h4, 32'h0000_080B);
    wr(BASE + 32'h4, 4'b0001, 32'h0000_0008);
    rd_chk("w1c_clear", BASE + 32'h4, 32'h0000_0803);
    n = 0;
    while (start_cyc < 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("ovf_started", 32'(start_cyc >= 0), 32'd1);
    while (cyc < start_cyc + 450) @(negedge clock);
    chk("pre_reset_tx", 32'(tx), 32'd0);
    reset = 1'b0;
    address = BASE + 32'h4; read_enable = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_tx_idle", 32'(tx_idle), 32'd1);
    chk("rst_mid_status", read_data, 32'h0000_0004);
    read_enable = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    rd_chk("post_rst_div", BASE + 32'h8, 32'd868);
    rd_chk("post_rst_status", BASE + 32'h4, 32'h0000_0004);
    repeat (20) @(negedge clock);
    chk("post_rst_tx", 32'(tx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
